mux_scan_sampler: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 10 +
 rtl/mux_scan_sampler_if.sv | 11 +
 rtl/mod_n_counter.sv | 24 ++
 rtl/mux_scan_sampler.sv | 73 +++++++
 tb/tb_mux_scan_sampler.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sampler: FSM state encoding.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } scan_state_t;

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Snapshot valid/ready channel between the scan sampler and its consumer.
interface mux_scan_sampler_if #(
   parameter int N = 16
);
   logic [N-1:0] snap;
   logic         snap_valid;
   logic         snap_ready;

   modport master (output snap, output snap_valid, input snap_ready);
   modport slave  (input snap, input snap_valid, output snap_ready);
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up counter; wraps at N-1 rather than at the power of two above it.
module mod_n_counter #(
   parameter  int N  = 16,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [SW-1:0] count,
   output logic          wrap
);
   localparam logic [SW-1:0] LAST = SW'(N - 1);

   assign wrap = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + SW'(1);
      end
   end
endmodule

// File: rtl/mux_scan_sampler.sv
// Walks an N-way 1-bit mux select, assembles an N-bit snapshot and offers it downstream.
module mux_scan_sampler
   import mux_scan_pkg::*;
#(
   parameter  int N  = 16,
   localparam int SW = $clog2(N)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic [SW-1:0]              sel,
   input  logic                       mux_f,
   output logic                       busy,
   mux_scan_sampler_if.master         snap_if
);
   scan_state_t  state, state_nx;
   logic         cnt_clr, cnt_en, wrap;
   logic [N-1:0] shadow, shadow_nx, snap_q;

   mod_n_counter #(.N(N)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (sel),
      .wrap  (wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (start) state_nx = ST_SCAN;
         end
         ST_SCAN: begin
            cnt_en = 1'b1;
            if (wrap) state_nx = ST_HOLD;
         end
         ST_HOLD: begin
            if (snap_if.snap_ready) state_nx = start ? ST_SCAN : ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Last channel lands in snap on the same edge it is sampled.
   always_comb begin
      shadow_nx      = shadow;
      shadow_nx[sel] = mux_f;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
         snap_q <= '0;
      end else if (state == ST_SCAN) begin
         shadow <= shadow_nx;
         if (wrap) snap_q <= shadow_nx;
      end
   end

   assign busy               = (state != ST_IDLE);
   assign snap_if.snap_valid = (state == ST_HOLD);
   assign snap_if.snap       = snap_q;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed self-checking bench for mux_scan_sampler at N=16 and N=5.
module tb_mux_scan_sampler;
   logic        clk = 1'b0;
   logic        reset;
   logic        start16, start5;
   logic [3:0]  sel16;
   logic [2:0]  sel5;
   logic        mux_f16, mux_f5;
   logic        busy16, busy5;
   logic [15:0] w16;
   logic [4:0]  w5;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   mux_scan_sampler_if #(.N(16)) if16 ();
   mux_scan_sampler_if #(.N(5))  if5 ();

   mux_scan_sampler #(.N(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .sel(sel16),
      .mux_f(mux_f16), .busy(busy16), .snap_if(if16)
   );

   mux_scan_sampler #(.N(5)) dut5 (
      .clk(clk), .reset(reset), .start(start5), .sel(sel5),
      .mux_f(mux_f5), .busy(busy5), .snap_if(if5)
   );

   assign mux_f16 = w16[sel16];
   assign mux_f5  = (sel5 < 3'd5) ? w5[sel5] : 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start16 = 1'b0; start5 = 1'b0;
      if16.snap_ready = 1'b0; if5.snap_ready = 1'b0;
      w16 = '0; w5 = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_sel", 32'(sel16), 0);
      chk("rst_busy", 32'(busy16), 0);
      chk("rst_snap", 32'(if16.snap), 0);
      chk("rst_valid", 32'(if16.snap_valid), 0);
      chk("rst5_snap", 32'(if5.snap), 0);

      // basic scan
      w16 = 16'hA5C3; start16 = 1'b1;
      step();
      start16 = 1'b0;
      chk("e0_busy", 32'(busy16), 1);
      chk("e0_sel", 32'(sel16), 0);
      for (int i = 1; i <= 15; i++) begin
         step();
         chk("scan_sel", 32'(sel16), 32'(i));
         chk("scan_valid", 32'(if16.snap_valid), 0);
      end
      step();
      chk("basic_valid", 32'(if16.snap_valid), 1);
      chk("basic_snap", 32'(if16.snap), 32'h0000A5C3);
      chk("basic_sel", 32'(sel16), 0);
      chk("basic_busy", 32'(busy16), 1);

      // backpressure: snap frozen, start ignored
      start16 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         w16 = 16'(i * 16'h1111 + 16'h0101);
         step();
         chk("bp_valid", 32'(if16.snap_valid), 1);
         chk("bp_snap", 32'(if16.snap), 32'h0000A5C3);
         chk("bp_sel", 32'(sel16), 0);
      end
      start16 = 1'b0; if16.snap_ready = 1'b1;
      step();
      chk("bp_rel_valid", 32'(if16.snap_valid), 0);
      chk("bp_rel_busy", 32'(busy16), 0);
      if16.snap_ready = 1'b0;

      // back-to-back
      w16 = 16'h1234; start16 = 1'b1; if16.snap_ready = 1'b1;
      step();
      chk("b2b_busy0", 32'(busy16), 1);
      for (int i = 1; i <= 16; i++) step();
      chk("b2b_valid1", 32'(if16.snap_valid), 1);
      chk("b2b_snap1", 32'(if16.snap), 32'h00001234);
      w16 = 16'hFFFF;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("b2b_busy", 32'(busy16), 1);
         chk("b2b_vtime", 32'(if16.snap_valid), (i == 17) ? 32'd1 : 32'd0);
      end
      chk("b2b_snap2", 32'(if16.snap), 32'h0000FFFF);
      start16 = 1'b0;
      step();
      chk("b2b_idle", 32'(busy16), 0);
      if16.snap_ready = 1'b0;

      // reset mid-scan
      w16 = 16'h5A0F; start16 = 1'b1;
      step();
      start16 = 1'b0;
      for (int i = 1; i <= 7; i++) step();
      chk("mid_sel7", 32'(sel16), 7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_sel", 32'(sel16), 0);
      chk("mrst_busy", 32'(busy16), 0);
      chk("mrst_snap", 32'(if16.snap), 0);
      chk("mrst_valid", 32'(if16.snap_valid), 0);
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      for (int i = 1; i <= 16; i++) step();
      chk("fresh_valid", 32'(if16.snap_valid), 1);
      chk("fresh_snap", 32'(if16.snap), 32'h00005A0F);
      if16.snap_ready = 1'b1;
      step();
      if16.snap_ready = 1'b0;
      chk("fresh_idle", 32'(busy16), 0);

      // start during scan is ignored
      w16 = 16'h0F0F; start16 = 1'b1;
      step();
      start16 = 1'b0;
      for (int i = 1; i <= 3; i++) step();
      chk("sds_sel3", 32'(sel16), 3);
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      chk("sds_sel4", 32'(sel16), 4);
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("sds_vtime", 32'(if16.snap_valid), (i == 12) ? 32'd1 : 32'd0);
      end
      chk("sds_snap", 32'(if16.snap), 32'h00000F0F);
      if16.snap_ready = 1'b1;
      step();
      if16.snap_ready = 1'b0;
      chk("sds_idle", 32'(busy16), 0);

      // non-power-of-two N=5
      w5 = 5'b10110; start5 = 1'b1;
      step();
      start5 = 1'b0;
      chk("n5_sel0", 32'(sel5), 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("n5_sel", 32'(sel5), 32'(i));
      end
      step();
      chk("n5_wrap", 32'(sel5), 0);
      chk("n5_valid", 32'(if5.snap_valid), 1);
      chk("n5_snap", 32'(if5.snap), 32'b10110);
      if5.snap_ready = 1'b1;
      step();
      if5.snap_ready = 1'b0;
      chk("n5_idle", 32'(busy5), 0);
      chk("n5_idle_sel", 32'(sel5), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
